// File: rtl/uart_transceiver.sv
// 8N1 UART physical layer: independent transmitter and receiver sharing only clk/rst.
// Busy flags and strobes are registered so the host-side handler sees clean, glitch-free levels.
module uart_transceiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t   tx_state_reg, tx_state_next;
  logic [15:0] tx_baud_reg, tx_baud_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic        tx_reg, tx_next;
  logic        tx_busy_reg, tx_busy_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_reg       <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_baud_reg  <= tx_baud_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_reg       <= tx_next;
      tx_busy_reg  <= tx_busy_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_baud_next  = tx_baud_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    case (tx_state_reg)
      TX_IDLE: begin
        if (transmit) begin
          tx_shift_next = tx_byte;
          tx_baud_next  = '0;
          tx_bit_next   = '0;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_baud_reg == BIT_LAST) begin
          tx_baud_next  = '0;
          tx_state_next = TX_DATA;
        end else begin
          tx_baud_next = tx_baud_reg + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_baud_reg == BIT_LAST) begin
          tx_baud_next  = '0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          tx_bit_next   = tx_bit_reg + 3'd1;
          if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
        end else begin
          tx_baud_next = tx_baud_reg + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_baud_reg == BIT_LAST) begin
          tx_baud_next  = '0;
          tx_state_next = TX_IDLE;
        end else begin
          tx_baud_next = tx_baud_reg + 16'd1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase

    // Line level is derived from the next state so tx itself comes straight from a flop.
    case (tx_state_next)
      TX_START: tx_next = 1'b0;
      TX_DATA:  tx_next = tx_shift_next[0];
      default:  tx_next = 1'b1;
    endcase
    tx_busy_next = (tx_state_next != TX_IDLE);
  end

  assign tx              = tx_reg;
  assign is_transmitting = tx_busy_reg;

  // ---------------- receiver ----------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   rx_s;
  logic                   rx_s_d_reg;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_next[gi] = rx;
    end else begin : g_rest
      assign sync_next[gi] = sync_reg[gi-1];
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_state_t;

  rx_state_t   rx_state_reg, rx_state_next;
  logic [15:0] rx_baud_reg, rx_baud_next;
  logic [2:0]  rx_bit_reg, rx_bit_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [7:0]  rx_byte_reg, rx_byte_next;
  logic        received_reg, received_next;
  logic        recv_error_reg, recv_error_next;
  logic        is_receiving_reg, is_receiving_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg         <= '1;
      rx_s_d_reg       <= 1'b1;
      rx_state_reg     <= RX_IDLE;
      rx_baud_reg      <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_byte_reg      <= '0;
      received_reg     <= 1'b0;
      recv_error_reg   <= 1'b0;
      is_receiving_reg <= 1'b0;
    end else begin
      sync_reg         <= sync_next;
      rx_s_d_reg       <= rx_s;
      rx_state_reg     <= rx_state_next;
      rx_baud_reg      <= rx_baud_next;
      rx_bit_reg       <= rx_bit_next;
      rx_shift_reg     <= rx_shift_next;
      rx_byte_reg      <= rx_byte_next;
      received_reg     <= received_next;
      recv_error_reg   <= recv_error_next;
      is_receiving_reg <= is_receiving_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    rx_baud_next    = rx_baud_reg;
    rx_bit_next     = rx_bit_reg;
    rx_shift_next   = rx_shift_reg;
    rx_byte_next    = rx_byte_reg;
    received_next   = 1'b0;
    recv_error_next = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_s_d_reg && !rx_s) begin
          rx_baud_next  = '0;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (rx_baud_reg == HALF_LAST) begin
          rx_baud_next = '0;
          rx_bit_next  = '0;
          if (!rx_s) begin
            rx_state_next = RX_DATA;
          end else begin
            recv_error_next = 1'b1;
            rx_state_next   = RX_IDLE;
          end
        end else begin
          rx_baud_next = rx_baud_reg + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_baud_reg == BIT_LAST) begin
          rx_baud_next  = '0;
          rx_shift_next = {rx_s, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
        end else begin
          rx_baud_next = rx_baud_reg + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_baud_reg == BIT_LAST) begin
          rx_baud_next = '0;
          if (rx_s) begin
            rx_byte_next  = rx_shift_reg;
            received_next = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            recv_error_next = 1'b1;
            rx_state_next   = RX_RECOVER;
          end
        end else begin
          rx_baud_next = rx_baud_reg + 16'd1;
        end
      end
      RX_RECOVER: begin
        // Hold off until the line idles so a stuck-low line cannot fake a start edge.
        if (rx_s) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
    is_receiving_next = (rx_state_next != RX_IDLE);
  end

  assign received     = received_reg;
  assign rx_byte      = rx_byte_reg;
  assign recv_error   = recv_error_reg;
  assign is_receiving = is_receiving_reg;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at 16 clocks per bit: reset, tx framing,
// rx back-to-back, framing error, false start, loopback and mid-frame reset.
module tb_uart_transceiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx;
  logic       tx;
  logic       transmit = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       received;
  logic [7:0] rx_byte;
  logic       is_receiving;
  logic       is_transmitting;
  logic       recv_error;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .tx             (tx),
    .transmit       (transmit),
    .tx_byte        (tx_byte),
    .received       (received),
    .rx_byte        (rx_byte),
    .is_receiving   (is_receiving),
    .is_transmitting(is_transmitting),
    .recv_error     (recv_error)
  );

  always @(negedge clk) begin
    if (received) rx_q.push_back(rx_byte);
    if (recv_error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (is_transmitting && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle_timeout", is_transmitting, 1'b0);
  endtask

  // Sends b over the looped line and tries to inject ign while the frame is in flight.
  task automatic loop_send(input logic [7:0] b, input logic [7:0] ign);
    transmit = 1'b1;
    tx_byte  = b;
    @(negedge clk);
    transmit = 1'b0;
    repeat (50) @(negedge clk);
    transmit = 1'b1;
    tx_byte  = ign;
    @(negedge clk);
    transmit = 1'b0;
    tx_byte  = 8'h00;
    chk("busy_during_ignore", is_transmitting, 1'b1);
    wait_tx_idle();
    $display("loopback tx 0x%02h sent (0x%02h ignored while busy)", b, ign);
  endtask

  initial begin
    logic [9:0] exp_frame;
    int bad;
    int base_q;
    int base_err;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy_tx", is_transmitting, 1'b0);
    chk("rst_received", received, 1'b0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_busy_rx", is_receiving, 1'b0);
    chk("rst_recv_error", recv_error, 1'b0);
    rst = 1'b0;
    $display("reset released");
    @(negedge clk);

    // Transmit 0xA5: check every cycle of the 10-bit frame
    transmit  = 1'b1;
    tx_byte   = 8'hA5;
    exp_frame = 10'b1_1010_0101_0;
    @(negedge clk);
    transmit = 1'b0;
    tx_byte  = 8'h00;
    chk("tx_busy_rise", is_transmitting, 1'b1);
    chk("tx_first_low", tx, 1'b0);
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== exp_frame[b] || is_transmitting !== 1'b1) bad++;
        if (b == 9 && c == CPB - 1) begin
          // Request in the last busy cycle must be dropped.
          transmit = 1'b1;
          tx_byte  = 8'h00;
        end
        @(negedge clk);
      end
      chk($sformatf("tx_bit%0d_bad_cycles", b), bad, 0);
    end
    transmit = 1'b0;
    chk("tx_busy_fall_at_160", is_transmitting, 1'b0);
    chk("tx_idle_high", tx, 1'b1);
    @(negedge clk);
    chk("tx_late_req_ignored", is_transmitting, 1'b0);
    chk("tx_late_req_line", tx, 1'b1);
    $display("tx frame 0xA5 checked");

    // Back-to-back rx frames
    base_q   = rx_q.size();
    base_err = err_cnt;
    send_rx(8'h4C, 1'b1);
    send_rx(8'h53, 1'b1);
    repeat (8) @(negedge clk);
    chk("b2b_count", rx_q.size() - base_q, 2);
    if (rx_q.size() - base_q == 2) begin
      chk("b2b_byte0", rx_q[base_q], 8'h4C);
      chk("b2b_byte1", rx_q[base_q+1], 8'h53);
    end
    chk("b2b_rx_byte", rx_byte, 8'h53);
    chk("b2b_no_error", err_cnt - base_err, 0);
    chk("b2b_idle", is_receiving, 1'b0);
    $display("rx frames 0x4C 0x53 back-to-back");

    // Framing error: stop bit 0, line held low afterwards
    base_q   = rx_q.size();
    base_err = err_cnt;
    send_rx(8'h3A, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_error_count", err_cnt - base_err, 1);
    chk("ferr_no_received", rx_q.size() - base_q, 0);
    chk("ferr_rx_byte_kept", rx_byte, 8'h53);
    chk("ferr_busy_while_low", is_receiving, 1'b1);
    rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    chk("ferr_recovered", is_receiving, 1'b0);
    $display("rx frame 0x3A with bad stop bit");

    // False start: 4-cycle glitch
    base_q   = rx_q.size();
    base_err = err_cnt;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    chk("glitch_busy", is_receiving, 1'b1);
    repeat (20) @(negedge clk);
    chk("glitch_error_count", err_cnt - base_err, 1);
    chk("glitch_no_received", rx_q.size() - base_q, 0);
    chk("glitch_idle", is_receiving, 1'b0);
    $display("rx glitch of 4 cycles");

    // Loopback
    loop_en  = 1'b1;
    base_q   = rx_q.size();
    base_err = err_cnt;
    loop_send(8'h00, 8'hFF);
    loop_send(8'hFF, 8'h30);
    loop_send(8'h30, 8'h55);
    repeat (10) @(negedge clk);
    chk("loop_count", rx_q.size() - base_q, 3);
    if (rx_q.size() - base_q == 3) begin
      chk("loop_byte0", rx_q[base_q], 8'h00);
      chk("loop_byte1", rx_q[base_q+1], 8'hFF);
      chk("loop_byte2", rx_q[base_q+2], 8'h30);
    end
    chk("loop_no_error", err_cnt - base_err, 0);

    // Reset in the middle of a looped frame
    base_q   = rx_q.size();
    base_err = err_cnt;
    transmit = 1'b1;
    tx_byte  = 8'h00;
    @(negedge clk);
    transmit = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_tx_low_before", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy_tx", is_transmitting, 1'b0);
    chk("midrst_busy_rx", is_receiving, 1'b0);
    chk("midrst_rx_byte", rx_byte, 8'h00);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrst_no_received", rx_q.size() - base_q, 0);
    chk("midrst_no_error", err_cnt - base_err, 0);
    chk("midrst_line_idle", tx, 1'b1);
    $display("reset asserted mid-frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Byte-level 8N1 UART physical layer that sits directly below the UART host-interface I/O handler.
- Serialises one byte on tx per transmit pulse and deserialises rx into bytes, reporting each with a one-cycle received strobe.
- Provides the busy flags the I/O handler uses to pace its character stream.
- Fixed format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal range 4..65535.
- SYNC_STAGES, 2, flip-flops in the rx metastability synchroniser; legal range 2..3.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rx  in  1  serial input, idle high, asynchronous to clk
- tx  out  1  serial output, idle high
- transmit  in  1  one-cycle request to send tx_byte
- tx_byte  in  8  byte to send; sampled only in the cycle transmit is accepted
- received  out  1  one-cycle strobe: rx_byte is valid
- rx_byte  out  8  last correctly framed byte; held until the next good frame
- is_receiving  out  1  high while the rx state machine is not idle
- is_transmitting  out  1  high from the cycle after transmit is accepted until the stop bit completes
- recv_error  out  1  one-cycle strobe: framing error or false start

Behaviour:
- Reset: tx=1, is_transmitting=0, received=0, rx_byte=0, is_receiving=0, recv_error=0. Both state machines return to IDLE; bit counters and the baud counter are cleared. Reset mid-frame aborts the frame immediately, and tx returns to 1 on the following edge.
- Widths: the baud counter is 16 bits and counts 0..CLKS_PER_BIT-1. The bit index is 3 bits.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - TX_IDLE: when transmit=1, latch tx_byte, go to TX_START, and set is_transmitting=1 on the next edge.
  - transmit is ignored while is_transmitting=1. No queueing, no error is flagged, and the latched byte is unchanged.
  - TX_START: tx=0 for CLKS_PER_BIT cycles.
  - TX_DATA: drive shift[0] for CLKS_PER_BIT cycles per bit, 8 bits, LSB first.
  - TX_STOP: tx=1 for CLKS_PER_BIT cycles, then TX_IDLE with is_transmitting=0.
  - Frame length: exactly 10*CLKS_PER_BIT cycles from the first tx=0 cycle to is_transmitting falling.
  - The first tx=0 cycle is the cycle after transmit.
  - transmit asserted in the same cycle is_transmitting falls is ignored. It is accepted one cycle later.
- RX: rx passes through SYNC_STAGES flops, giving rx_s. Edge detection uses rx_s and its delayed copy.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER.
  - RX_IDLE: a falling edge on rx_s moves to RX_START and sets is_receiving=1.
  - RX_START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s.
    - If 0: go to RX_DATA.
    - If 1 (false start): pulse recv_error and go to RX_IDLE.
  - RX_DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit), shifting into bit 7 so the first bit ends in bit 0. After 8 samples go to RX_STOP.
  - RX_STOP: sample once, CLKS_PER_BIT after the last data sample.
    - If 1: rx_byte <= shift and received=1 for one cycle, in the same cycle, then RX_IDLE.
    - If 0 (framing error): recv_error=1 for one cycle, rx_byte unchanged, then RX_RECOVER.
  - RX_RECOVER: wait until rx_s=1, then RX_IDLE. is_receiving stays high throughout.
- is_receiving drops in the cycle the FSM enters RX_IDLE.
- A new start edge is honoured from the first RX_IDLE cycle, so back-to-back frames with no idle gap are received.
- TX and RX are fully independent. Simultaneous transmit and received activity is legal, so loopback of tx to rx must work.

Test Plan:
- Sim with CLKS_PER_BIT=16. Reset held 3 cycles -> tx=1, all strobes and busy flags 0, rx_byte=8'h00.
- Pulse transmit with tx_byte=8'hA5 -> is_transmitting rises next cycle. tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. is_transmitting falls exactly 160 cycles after the first tx=0.
- Drive rx frame 8'h4C, then immediately 8'h53 with no gap -> two received pulses, rx_byte=8'h4C then 8'h53, recv_error never set.
- Drive rx frame 8'h3A with stop bit 0 -> recv_error pulses once, no received pulse, rx_byte keeps its previous value. is_receiving stays high until rx returns to 1.
- Glitch rx low for 4 cycles -> recv_error pulse at the half-bit sample, no received pulse, FSM back to idle.
- Loopback tx->rx. Send 8'h00, 8'hFF, 8'h30 (second transmit while busy is ignored; resend after busy drops) -> received bytes equal 8'h00, 8'hFF, 8'h30. Also assert rst mid-frame -> tx=1 next cycle and no received pulse.
